// File: rtl/datapath_pkg.sv
// Shared definitions for the two-stage register/ALU/memory datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: alu_op_e opcode enum, default width/depth constants, carry-op helper.
package datapath_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_REG_N     = 16;
  localparam int DEF_MEM_DEPTH = 256;

  // Codes 10..15 are deliberately unnamed; the ALU returns 0 for them.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_SHL1  = 4'd6,
    ALU_SHR1  = 4'd7,
    ALU_PASSA = 4'd8,
    ALU_PASSB = 4'd9
  } alu_op_e;

  // Only ADD and SUB produce a meaningful carry/borrow.
  function automatic logic alu_sets_carry(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU for the datapath: arithmetic, logic, shifts and passes.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
// Ports: a, b operands; op 4-bit opcode (alu_op_e codes); q result; carry
// (ADD carry-out, SUB borrow, 0 otherwise).
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] q,
  output logic              carry
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum   = '0;
    q     = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        q     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      ALU_SUB: begin
        // Zero-extended subtract: the top bit is set exactly when a < b.
        sum   = {1'b0, a} - {1'b0, b};
        q     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      ALU_AND:   q = a & b;
      ALU_OR:    q = a | b;
      ALU_XOR:   q = a ^ b;
      ALU_NOT:   q = ~a;
      ALU_SHL1:  q = {a[DATA_W-2:0], 1'b0};
      ALU_SHR1:  q = {1'b0, a[DATA_W-1:1]};
      ALU_PASSA: q = a;
      ALU_PASSB: q = b;
      default:   q = '0;
    endcase
  end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage datapath: EX (reg read, ALU, sync memory) then WB (mux, reg write).
// Latency: 1 cycle from issue to wb_valid/wb_data; flags valid 1 cycle after issue.
// Backpressure: none; one instruction accepted per cycle whenever issue is high.
// Ports: clk/rst_n (async active-low); issue + D_Addr/D_wr/RF_s/RF_W_addr/
// RF_W_en/RF_Ra_addr/RF_Rb_addr/Alu_s0 instruction fields; wb_valid/wb_data
// write-back view; flag_z/flag_c registered ALU flags.
// Option: define DATAPATH_FWD_EN to bypass the WB value into EX operands;
// without it dependent instructions need one idle cycle between them.
module pipe_datapath
  import datapath_pkg::*;
#(
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  REG_N     = DEF_REG_N,
  parameter int  MEM_DEPTH = DEF_MEM_DEPTH,
  localparam int RA_W      = $clog2(REG_N),
  localparam int MA_W      = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [MA_W-1:0]   D_Addr,
  input  logic              D_wr,
  input  logic              RF_s,
  input  logic [RA_W-1:0]   RF_W_addr,
  input  logic              RF_W_en,
  input  logic [RA_W-1:0]   RF_Ra_addr,
  input  logic [RA_W-1:0]   RF_Rb_addr,
  input  logic [3:0]        Alu_s0,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_z,
  output logic              flag_c
);

  logic [DATA_W-1:0] rf  [REG_N];
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic [DATA_W-1:0] wb_alu;
  logic              wb_sel;
  logic [RA_W-1:0]   wb_addr;
  logic              wb_we;

  logic [DATA_W-1:0] a_op;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W-1:0] alu_q;
  logic              alu_c;

  // ---------------- EX: operand read ----------------
`ifdef DATAPATH_FWD_EN
  logic fwd_a;
  logic fwd_b;
  assign fwd_a = wb_valid && wb_we && (wb_addr == RF_Ra_addr);
  assign fwd_b = wb_valid && wb_we && (wb_addr == RF_Rb_addr);
  assign a_op  = fwd_a ? wb_data : rf[RF_Ra_addr];
  assign b_op  = fwd_b ? wb_data : rf[RF_Rb_addr];
`else
  assign a_op  = rf[RF_Ra_addr];
  assign b_op  = rf[RF_Rb_addr];
`endif

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (a_op),
    .b     (b_op),
    .op    (Alu_s0),
    .q     (alu_q),
    .carry (alu_c)
  );

  // Data memory: not reset. Non-blocking read and write on the same edge
  // give read-first behaviour for a same-address read/write.
  always_ff @(posedge clk) begin
    if (issue) begin
      if (D_wr) begin
        mem[D_Addr] <= a_op;
      end
      mem_q <= mem[D_Addr];
    end
  end

  // ---------------- EX/WB pipeline register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_alu   <= '0;
      wb_sel   <= 1'b0;
      wb_addr  <= '0;
      wb_we    <= 1'b0;
    end else begin
      wb_valid <= issue;
      if (issue) begin
        wb_alu  <= alu_q;
        wb_sel  <= RF_s;
        wb_addr <= RF_W_addr;
        wb_we   <= RF_W_en;
      end
    end
  end

  // Gated by wb_valid so idle cycles and reset both present zero.
  assign wb_data = wb_valid ? (wb_sel ? mem_q : wb_alu) : '0;

  // ---------------- WB: register file write ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        rf[i] <= '0;
      end
    end else if (wb_valid && wb_we) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // ---------------- Flags ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (issue) begin
      flag_z <= (alu_q == '0);
      if (alu_sets_carry(Alu_s0)) begin
        flag_c <= alu_c;
      end
    end
  end

endmodule

// File: tb/tb_pipe_datapath.sv
// Scoreboard bench for pipe_datapath: stimulus pushes expected wb_data,
// a negedge monitor pops and compares whenever wb_valid is high.
module tb_pipe_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue = 1'b0;
  logic [7:0]  D_Addr = '0;
  logic        D_wr = 1'b0;
  logic        RF_s = 1'b0;
  logic [3:0]  RF_W_addr = '0;
  logic        RF_W_en = 1'b0;
  logic [3:0]  RF_Ra_addr = '0;
  logic [3:0]  RF_Rb_addr = '0;
  logic [3:0]  Alu_s0 = '0;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic        flag_z;
  logic        flag_c;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  pipe_datapath dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .D_Addr     (D_Addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .Alu_s0     (Alu_s0),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .flag_z     (flag_z),
    .flag_c     (flag_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: wb_data is a function of registered state only, so negedge is safe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 32'(wb_data), 32'hDEAD_BEEF);
        end else begin
          chk("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
        end
      end else begin
        chk("wb_idle_zero", 32'(wb_data), 32'h0);
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1 with issue low.
  task automatic do_issue(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] w, input logic we, input logic s,
                          input logic dwr, input logic [7:0] addr,
                          input logic [15:0] exp, input logic push);
    Alu_s0 = op; RF_Ra_addr = ra; RF_Rb_addr = rb; RF_W_addr = w;
    RF_W_en = we; RF_s = s; D_wr = dwr; D_Addr = addr;
    issue = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    issue = 1'b0; D_wr = 1'b0; RF_W_en = 1'b0; RF_s = 1'b0;
  endtask

  task automatic alu(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                     input logic [3:0] w, input logic we, input logic [15:0] exp);
    do_issue(op, ra, rb, w, we, 1'b0, 1'b0, 8'h00, exp, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flags(input string nm, input logic z, input logic c);
    chk({nm, "_z"}, 32'(flag_z), 32'(z));
    chk({nm, "_c"}, 32'(flag_c), 32'(c));
  endtask

  initial begin
    logic [15:0] r5_exp;
`ifdef DATAPATH_FWD_EN
    r5_exp = 16'h0004;
`else
    r5_exp = 16'h0000;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_wb_data", 32'(wb_data), 32'h0);
    flags("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(1);

    // ADD R1 = R0 + R0 after reset
    alu(4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0000);
    flags("add_zero", 1'b1, 1'b0);
    // Build constants from R0 = 0, idle between dependent ops
    alu(4'd5, 4'd0, 4'd0, 4'd9, 1'b1, 16'hFFFF);   idle(1); // R9 = FFFF
    flags("not", 1'b0, 1'b0);
    alu(4'd1, 4'd0, 4'd9, 4'd10, 1'b1, 16'h0001);  idle(1); // R10 = 1
    flags("sub_borrow", 1'b0, 1'b1);
    alu(4'd6, 4'd10, 4'd0, 4'd11, 1'b1, 16'h0002); idle(1); // R11 = 2
    flags("shl_holds_c", 1'b0, 1'b1);
    alu(4'd0, 4'd10, 4'd11, 4'd3, 1'b1, 16'h0003); idle(1); // R3 = 3
    flags("add_nc", 1'b0, 1'b0);
    alu(4'd6, 4'd11, 4'd0, 4'd12, 1'b1, 16'h0004); idle(1); // R12 = 4
    alu(4'd0, 4'd12, 4'd10, 4'd2, 1'b1, 16'h0005); idle(1); // R2 = 5

    // Back-to-back dependency: SUB R4 = R2 - R3; ADD R5 = R4 + R4
    alu(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 16'h0002);
    alu(4'd0, 4'd4, 4'd4, 4'd5, 1'b1, r5_exp);
    idle(1);
    alu(4'd8, 4'd5, 4'd0, 4'd0, 1'b0, r5_exp);
    alu(4'd9, 4'd0, 4'd4, 4'd0, 1'b0, 16'h0002);

    // SUB 1 - 2 -> FFFF with borrow
    alu(4'd1, 4'd10, 4'd11, 4'd13, 1'b1, 16'hFFFF);
    flags("sub_neg", 1'b0, 1'b1);

    // Memory: seed 0x10 with 3, then store 5 while loading (read-first)
    do_issue(4'd8, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h10, 16'h0003, 1'b1);
    do_issue(4'd8, 4'd2, 4'd0, 4'd6, 1'b1, 1'b1, 1'b1, 8'h10, 16'h0003, 1'b1);
    do_issue(4'd8, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 1'b0, 8'h10, 16'h0005, 1'b1);
    idle(1);
    alu(4'd8, 4'd6, 4'd0, 4'd0, 1'b0, 16'h0003);
    alu(4'd8, 4'd7, 4'd0, 4'd0, 1'b0, 16'h0005);
    flags("pre_idle", 1'b0, 1'b1);

    // Idle cycles with live-looking controls must change nothing
    D_wr = 1'b1; D_Addr = 8'h10; RF_Ra_addr = 4'd9; RF_W_en = 1'b1;
    RF_W_addr = 4'd7; Alu_s0 = 4'd0; RF_Rb_addr = 4'd9;
    idle(3);
    flags("idle_hold", 1'b0, 1'b1);
    D_wr = 1'b0; RF_W_en = 1'b0;
    do_issue(4'd8, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0005, 1'b1);
    alu(4'd8, 4'd7, 4'd0, 4'd0, 1'b0, 16'h0005);

    // Remaining ops, no register writes
    alu(4'd2, 4'd2, 4'd3, 4'd0, 1'b0, 16'h0001);
    alu(4'd3, 4'd2, 4'd3, 4'd0, 1'b0, 16'h0007);
    alu(4'd4, 4'd2, 4'd3, 4'd0, 1'b0, 16'h0006);
    alu(4'd7, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0002);
    alu(4'd6, 4'd9, 4'd0, 4'd0, 1'b0, 16'hFFFE);
    alu(4'd7, 4'd9, 4'd0, 4'd0, 1'b0, 16'h7FFF);
    alu(4'd0, 4'd10, 4'd10, 4'd0, 1'b0, 16'h0002);
    flags("add_small", 1'b0, 1'b0);
    alu(4'd0, 4'd9, 4'd10, 4'd0, 1'b0, 16'h0000);
    flags("add_wrap", 1'b1, 1'b1);

    // Undefined opcode into R2
    alu(4'd1, 4'd3, 4'd2, 4'd0, 1'b0, 16'hFFFE);  // 3 - 5: sets z=0, c=1
    alu(4'hC, 4'd3, 4'd3, 4'd2, 1'b1, 16'h0000);
    flags("op_c", 1'b1, 1'b1);
    idle(3);
    flags("op_c_idle", 1'b1, 1'b1);
    alu(4'd8, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0000);

    // Reset while an instruction sits in WB (not pushed: it is discarded)
    do_issue(4'd1, 4'd10, 4'd3, 4'd14, 1'b1, 1'b0, 1'b0, 8'h00, 16'hFFFE, 1'b0);
    chk("pre_rst_vld", 32'(wb_valid), 32'h1);
    chk("pre_rst_c", 32'(flag_c), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", 32'(wb_valid), 32'h0);
    chk("arst_wb_data", 32'(wb_data), 32'h0);
    flags("arst", 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    alu(4'd8, 4'd14, 4'd0, 4'd0, 1'b0, 16'h0000);
    alu(4'd8, 4'd7, 4'd0, 4'd0, 1'b0, 16'h0000);
    idle(2);

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
